// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers and a fixed-latency busy window.
// Optional divider enabled by defining MDU_DIV_EN; without it div/divu are never accepted.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_RS,
  input  logic [31:0] E_RT,
  input  logic [3:0]  op,
  input  logic        start,
  input  logic        req,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] out
);

  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [31:0] hi_reg, lo_reg, phi_reg, plo_reg;

  logic        is_mul, is_div, accept, commit;
  logic        mt_hi, mt_lo;
  logic [63:0] rs_sx, rt_sx, prod_s, prod_u;
  logic [63:0] result;

  assign is_mul = (op == 4'd1) || (op == 4'd2);
`ifdef MDU_DIV_EN
  assign is_div = (op == 4'd3) || (op == 4'd4);
`else
  assign is_div = 1'b0;
`endif

  assign accept = (state_reg == IDLE) && start && !req && (is_mul || is_div);
  assign commit = (state_reg == BUSY) && (cnt_reg == 5'd0);
  assign mt_hi  = (state_reg == IDLE) && !req && (op == 4'd7);
  assign mt_lo  = (state_reg == IDLE) && !req && (op == 4'd8);

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign rs_sx  = {{32{E_RS[31]}}, E_RS};
  assign rt_sx  = {{32{E_RT[31]}}, E_RT};
  assign prod_s = rs_sx * rt_sx;
  assign prod_u = {32'h0, E_RS} * {32'h0, E_RT};

`ifdef MDU_DIV_EN
  logic [31:0] div_q, div_r;

  always_comb begin
    div_q = '0;
    div_r = '0;
    if (E_RT == 32'h0) begin
      div_q = 32'hFFFF_FFFF;
      div_r = E_RS;
    end else if (op == 4'd3) begin
      if (E_RS == 32'h8000_0000 && E_RT == 32'hFFFF_FFFF) begin
        div_q = 32'h8000_0000;
        div_r = 32'h0;
      end else begin
        div_q = $signed(E_RS) / $signed(E_RT);
        div_r = $signed(E_RS) % $signed(E_RT);
      end
    end else begin
      div_q = E_RS / E_RT;
      div_r = E_RS % E_RT;
    end
  end
`endif

  always_comb begin
    result = '0;
    case (op)
      4'd1: result = prod_s;
      4'd2: result = prod_u;
`ifdef MDU_DIV_EN
      4'd3, 4'd4: result = {div_r, div_q};
`endif
      default: result = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 5'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = BUSY;
          cnt_next   = is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_reg == 5'd0) state_next = IDLE;
        else                 cnt_next   = cnt_reg - 5'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_reg == BUSY);
    HI   = hi_reg;
    LO   = lo_reg;
    case (op)
      4'd5:    out = hi_reg;
      4'd6:    out = lo_reg;
      default: out = 32'h0;
    endcase
  end

  // Pending result is latched at acceptance and only reaches HI/LO on commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phi_reg <= '0;
      plo_reg <= '0;
      hi_reg  <= '0;
      lo_reg  <= '0;
    end else begin
      if (accept) begin
        phi_reg <= result[63:32];
        plo_reg <= result[31:0];
      end
      if (commit) begin
        hi_reg <= phi_reg;
        lo_reg <= plo_reg;
      end else begin
        if (mt_hi) hi_reg <= E_RS;
        if (mt_lo) lo_reg <= E_RS;
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vectors then randomized traffic against a reference model.
// Div checks adapt to whether MDU_DIV_EN is defined.
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] E_RS, E_RT;
  logic [3:0]  op;
  logic        start, req;
  logic        busy;
  logic [31:0] HI, LO, out;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_left;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .E_RS(E_RS), .E_RT(E_RT), .op(op),
    .start(start), .req(req), .busy(busy), .HI(HI), .LO(LO), .out(out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit div_enabled();
`ifdef MDU_DIV_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // {HI,LO} from plain arithmetic on 64-bit integers
  function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    int     sa, sb;
    longint la, lb, q, r;
    logic [63:0] ua, ub;
    sa = a; sb = b;
    la = sa; lb = sb;
    ua = {32'h0, a}; ub = {32'h0, b};
    case (o)
      4'd1: return 64'(la * lb);
      4'd2: return ua * ub;
      4'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = la / lb;
        r = la - q * lb;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return 64'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_left = 0;
  endtask

  task automatic model_edge();
    logic [63:0] res;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (!req) begin
      if (start && (op == 1 || op == 2 || (div_enabled() && (op == 3 || op == 4)))) begin
        res    = ref_result(op, E_RS, E_RT);
        m_phi  = res[63:32];
        m_plo  = res[31:0];
        m_left = (op <= 2) ? MC : DC;
        $display("txn accept op=%0d rs=%h rt=%h -> hi=%h lo=%h", op, E_RS, E_RT, m_phi, m_plo);
      end else if (op == 7) m_hi = E_RS;
      else if (op == 8) m_lo = E_RS;
    end
  endtask

  // one clock: drive at negedge, check comb out, clock, check registered outputs
  task automatic cyc(input logic [3:0] o, input logic s, input logic r,
                     input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_out;
    op = o; start = s; req = r; E_RS = a; E_RT = b;
    #1;
    exp_out = (o == 5) ? m_hi : (o == 6) ? m_lo : 32'h0;
    chk("out", out, exp_out);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk("busy", {31'h0, busy}, {31'h0, m_left > 0});
    chk("HI", HI, m_hi);
    chk("LO", LO, m_lo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'd0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0; op = 0; start = 0; req = 0; E_RS = 0; E_RT = 0;
    model_reset();
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_HI", HI, 32'h0);
    chk("rst_LO", LO, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // signed multiply -2 * 3, first edge after reset release
    cyc(4'd1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3);
    for (int i = 0; i < MC; i++) begin
      chk("mult_busy", {31'h0, busy}, 32'h1);
      idle(1);
    end
    chk("mult_busy_done", {31'h0, busy}, 32'h0);
    chk("mult_HI", HI, 32'hFFFF_FFFF);
    chk("mult_LO", LO, 32'hFFFF_FFFA);

    // unsigned multiply max*max
    cyc(4'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(MC);
    chk("multu_HI", HI, 32'hFFFF_FFFE);
    chk("multu_LO", LO, 32'h0000_0001);

    // mthi blocked by req, then taken; read back with mfhi
    cyc(4'd7, 1'b0, 1'b1, 32'h1234, 32'h0);
    chk("mthi_req_HI", HI, 32'hFFFF_FFFE);
    cyc(4'd7, 1'b0, 1'b0, 32'h1234, 32'h0);
    chk("mthi_HI", HI, 32'h1234);
    cyc(4'd5, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(4'd8, 1'b0, 1'b0, 32'hCAFE_0001, 32'h0);
    cyc(4'd6, 1'b0, 1'b0, 32'h0, 32'h0);

    // mt and restart attempts while busy are ignored
    cyc(4'd1, 1'b1, 1'b0, 32'd7, 32'd6);
    cyc(4'd7, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0);
    cyc(4'd2, 1'b1, 1'b0, 32'd9, 32'd9);
    idle(MC);
    chk("busy_ign_LO", LO, 32'd42);

`ifdef MDU_DIV_EN
    cyc(4'd3, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
    idle(DC);
    chk("div_LO", LO, 32'hFFFF_FFFD);
    chk("div_HI", HI, 32'hFFFF_FFFF);
    cyc(4'd4, 1'b1, 1'b0, 32'd5, 32'd0);
    idle(DC);
    chk("divu0_LO", LO, 32'hFFFF_FFFF);
    chk("divu0_HI", HI, 32'd5);
    cyc(4'd3, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(DC);
    chk("divovf_LO", LO, 32'h8000_0000);
    chk("divovf_HI", HI, 32'h0);
    // req+start mid-divide must not disturb the in-flight result
    cyc(4'd3, 1'b1, 1'b0, 32'd100, 32'd7);
    idle(3);
    cyc(4'd4, 1'b1, 1'b1, 32'd1, 32'd1);
    idle(DC - 4);
    chk("divreq_LO", LO, 32'd14);
    chk("divreq_HI", HI, 32'd2);
`else
    cyc(4'd3, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
    chk("nodiv_busy", {31'h0, busy}, 32'h0);
    cyc(4'd4, 1'b1, 1'b0, 32'd5, 32'd0);
    chk("nodivu_LO", LO, 32'd42);
`endif

    // start with a reserved op is ignored
    cyc(4'd12, 1'b1, 1'b0, 32'd3, 32'd3);
    chk("resv_busy", {31'h0, busy}, 32'h0);

    // reset in busy cycle 3 aborts the multiply
    cyc(4'd1, 1'b1, 1'b0, 32'd1000, 32'd1000);
    idle(2);
    reset = 1'b0;
    #1;
    model_reset();
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_HI", HI, 32'h0);
    chk("abort_LO", LO, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    idle(MC + 1);
    chk("abort_LO_later", LO, 32'h0);
    cyc(4'd2, 1'b1, 1'b0, 32'd3, 32'd4);
    chk("post_rst_accept", {31'h0, busy}, 32'h1);
    idle(MC);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [3:0] ro;
      ro = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
      cyc(ro, ($urandom_range(0, 2) != 0), ($urandom_range(0, 5) == 0), rand_operand(), rand_operand());
    end
    idle(DC + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy duration of mult/multu in cycles, legal range 1..31.
REQ-002 Parameter DIV_CYCLES, default 10: busy duration of div/divu in cycles, legal range 1..31.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately, independent of clk.
REQ-005 E_RS  input  32  rs operand forwarded in E stage from the D2E register.
REQ-006 E_RT  input  32  rt operand forwarded in E stage from the D2E register.
REQ-007 op  input  4  E-stage operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 reserved, treated as none.
REQ-008 start  input  1  asserted by E-stage decode in the same cycle as op 1-4.
REQ-009 req  input  1  exception/interrupt request; suppresses state-changing ops in the current cycle.
REQ-010 busy  output  1  registered; 1 while a multiply/divide is in flight.
REQ-011 HI  output  32  architectural HI register.
REQ-012 LO  output  32  architectural LO register.
REQ-013 out  output  32  combinational: HI when op=5, LO when op=6, else 32'h0.

Function
REQ-014 FSM states: IDLE, BUSY; a 5-bit down-counter cnt.
REQ-015 Accept condition: state IDLE, start=1, req=0, op in 1-4; acceptance takes place on the rising edge of that cycle T.
REQ-016 On acceptance: result computed from E_RS/E_RT as sampled at T and held in pending regs pHI/pLO; cnt loaded with N-1 (N=MULT_CYCLES or DIV_CYCLES); state goes to BUSY; busy=1 from cycle T+1.
REQ-017 In BUSY, cnt decrements each cycle; on the edge where cnt=0, HI<=pHI, LO<=pLO and state goes to IDLE; busy=1 for exactly N cycles (T+1..T+N), and new HI/LO become visible in T+N+1 with busy=0.
REQ-018 mult: {HI,LO} = signed 64-bit product; multu: unsigned 64-bit product.
REQ-019 div: LO = signed quotient truncated toward zero, HI = remainder with the sign of the dividend; divu: unsigned quotient and remainder.
REQ-020 Divide by zero (div and divu): LO=32'hFFFF_FFFF, HI=dividend.
REQ-021 Signed overflow, div with 32'h8000_0000 / 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0.
REQ-022 mthi (op 7) / mtlo (op 8) write E_RS to HI / LO at the edge when state is IDLE and req=0; HI/LO are otherwise unchanged.
REQ-023 start asserted, or op 7/8 presented, while BUSY: ignored with no state change (upstream stalls on start|busy and on mf/mt while busy).
REQ-024 req=1 while BUSY: the in-flight operation SHALL complete normally; req only blocks new acceptances and mt writes.
REQ-025 start=1 with op outside 1-4: ignored.
REQ-026 out SHALL reflect the current HI/LO register values, not the pending values.

Reset
REQ-027 On reset=0: state=IDLE, cnt=0, busy=0, HI=0, LO=0, pHI=0, pLO=0.
REQ-028 Reset asserted mid-operation SHALL abort the operation; HI/LO SHALL NOT receive the pending result.
REQ-029 After reset is released, the first rising edge SHALL be able to accept an operation.

Configuration
REQ-030 Macro MDU_DIV_EN: when defined, div/divu are implemented as specified above.
REQ-031 Without MDU_DIV_EN: op 3/4 are never accepted, busy stays 0, HI/LO stay unchanged, and no divider logic is synthesised; mult/multu/mf/mt are unaffected.

Verification
REQ-032 mult with E_RS=32'hFFFF_FFFE (-2), E_RT=3 -> busy=1 for 5 cycles; then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA.
REQ-033 multu with E_RS=E_RT=32'hFFFF_FFFF -> after 5 busy cycles, HI=32'hFFFF_FFFE, LO=32'h0000_0001.
REQ-034 div with E_RS=-7, E_RT=2 -> busy=1 for 10 cycles; then LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF; divu 5/0 -> LO=32'hFFFF_FFFF, HI=5.
REQ-035 mthi with E_RS=32'h1234 and req=1 -> HI unchanged; the same stimulus with req=0 -> HI=32'h1234 and out=32'h1234 under op=5.
REQ-036 Start a mult, then assert reset=0 at busy cycle 3 -> busy=0 and HI=LO=0 immediately, and the result is never written.
REQ-037 Start a div, then pulse req=1 and start=1 at busy cycle 4 -> original result written at cycle 10, and the second start is ignored.
